logic_stream_reducer: RTL and testbench
=======================================

# logic_stream_reducer

Parametrised, handshaked successor to the team's bitwise two-input gate blocks. It reduces a stream of `len+1` words of `WIDTH` bits into one result, using a run-time selected operation (OR, AND, XOR or NOR) applied per bit. The combinational datapath is built from C2 logic cells: one cell per bit per operation, with `out = D[{A1|B1, A0&B0}]`. The block sits between a word producer and a result consumer, both using valid/ready handshakes.

## Interface
- `WIDTH`, 8: data word width in bits (≥1).
- `LEN_W`, 4: width of the length field. The block reduces 1 to 2^LEN_W words per operation.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  begin an operation. Sampled only in IDLE.
- `op`  in  2  operation select: 00 OR, 01 AND, 10 XOR, 11 NOR. Latched on an accepted `start`.
- `len`  in  LEN_W  number of words minus 1. Latched on an accepted `start`.
- `in_valid`  in  1  `in_data` is valid.
- `in_data`  in  WIDTH  input word.
- `in_ready`  out  1  block accepts a word this cycle.
- `out_valid`  out  1  `out_data` holds the final result.
- `out_data`  out  WIDTH  reduction result.
- `out_ready`  in  1  consumer accepts the result.
- `busy`  out  1  high whenever the state is not IDLE.

## Operation
- FSM states: IDLE, ACCUM, DONE. All state is registered; the next-state and datapath logic is combinational.
- **IDLE**
  - `start`=1 latches `op` into `op_r` and `len` into `len_r`, clears `cnt`, and moves to ACCUM.
  - `in_data` is ignored in IDLE.
- **ACCUM**
  - `in_ready`=1.
  - A word is accepted on a clock edge where `in_valid & in_ready`.
  - First accepted word (`cnt`==0): `acc <= in_data`. This is a load, not a reduction.
  - Later accepted words: `acc <= acc OP in_data`.
    - For OR and NOR, the accumulated operation is OR.
    - For AND it is AND; for XOR it is XOR.
  - Each accepted word increments `cnt`. `cnt` is LEN_W+1 bits wide so it cannot wrap.
  - When an accepted word has `cnt == len_r`, the state moves to DONE.
  - Cycles with `in_valid`=0 leave `acc` and `cnt` unchanged. Gaps are allowed anywhere in the stream.
- **DONE**
  - `out_valid`=1.
  - `out_data = acc`, or `~acc` when `op_r`=11 (NOR).
  - `out_data` is held stable until `out_valid & out_ready`; the state then returns to IDLE.
- `start` in ACCUM or DONE is ignored and does not change `op_r` or `len_r`.
- `start` on the same cycle that DONE hands off is ignored. It must be reasserted once the block is in IDLE.
- Changes to `op` or `len` after the accepted `start` have no effect.
- Outside DONE, `out_data` = 0.

## Timing
- Reset (asynchronous, immediate, independent of `clk`):
  - state = IDLE; `acc`, `cnt`, `op_r`, `len_r` = 0.
  - `in_ready`=0, `out_valid`=0, `out_data`=0, `busy`=0.
- Reset in the middle of an operation aborts it. No partial result is emitted, and the next `start` after release runs normally.
- `in_ready`, `out_valid`, `busy` and `out_data` are decoded from registered state only. There is no combinational path from any input to any output.
- Sequence, with `start` sampled at edge k:
  - ACCUM begins at k+1, so `in_ready` is high from the cycle after k.
  - The last word is accepted at edge m; `out_valid` is high from m+1.
- With `in_valid` held high, the first word is accepted at edge k+1, so `out_valid` rises 1 + (`len`+1) cycles after `start` is sampled.
- With `out_ready` held high, the handshake takes 1 cycle in DONE. The next `start` can be sampled at the edge after that hand-off.

## Test plan
- OR, `len`=2, words 0x01, 0x10, 0x80 sent back-to-back, `out_ready`=1 → `out_valid` for exactly 1 cycle with `out_data`=0x91; `busy` falls on the following cycle.
- AND, `len`=2, words 0xFF, 0x0F, 0x3C with 2-cycle `in_valid` gaps between words → `out_data`=0x0C; `in_ready` stays high through the gaps.
- XOR, `len`=0, single word 0xA5 → `out_data`=0xA5 (load path only). Then XOR, `len`=15, words 1..16 → `out_data`=0x10, with `cnt` reaching 16 and no wrap.
- NOR, `len`=1, words 0x0F, 0x30, `out_ready` held low for 3 cycles → `out_data`=0xC0 held stable with `out_valid`=1 throughout. `start`, `op` and `len` toggled during DONE have no effect.
- Reset asserted asynchronously mid-ACCUM after 2 of 4 words → all outputs 0 immediately. A subsequent OR, `len`=0, word 0x5A → 0x5A, with no leftover state from the aborted operation.

Source files
------------

// File: rtl/logic_stream_reducer_if.sv
// Handshake bundle between a word producer, the stream reducer and a result consumer.
interface logic_stream_reducer_if #(
    parameter int WIDTH = 8,
    parameter int LEN_W = 4
);
    logic               start;
    logic [1:0]         op;
    logic [LEN_W-1:0]   len;
    logic               in_valid;
    logic [WIDTH-1:0]   in_data;
    logic               in_ready;
    logic               out_valid;
    logic [WIDTH-1:0]   out_data;
    logic               out_ready;
    logic               busy;

    // Producer/consumer side drives commands, words and result acceptance.
    modport master (
        output start, op, len, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, busy
    );

    // Reducer side.
    modport slave (
        input  start, op, len, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, busy
    );
endinterface

// File: rtl/logic_stream_reducer.sv
// Reduces len+1 words into one result with a per-bit OR/AND/XOR/NOR built from
// C2 logic cells (out = D[{A1|B1, A0&B0}]). All outputs come straight from
// registers, so there is no input-to-output combinational path.
module logic_stream_reducer #(
    parameter int WIDTH = 8,
    parameter int LEN_W = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    logic_stream_reducer_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [1:0] OP_OR  = 2'b00;
    localparam logic [1:0] OP_AND = 2'b01;
    localparam logic [1:0] OP_XOR = 2'b10;
    localparam logic [1:0] OP_NOR = 2'b11;

    // Cell truth tables; XOR reuses the OR table but feeds both input pairs,
    // so {a|b, a&b} = 2'b11 selects D[3]=0.
    localparam logic [3:0] D_OR  = 4'b0100;
    localparam logic [3:0] D_AND = 4'b0010;
    localparam logic [3:0] D_XOR = 4'b0100;

    state_t             state_q;
    logic [1:0]         op_q;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W:0]     cnt_q;
    logic [WIDTH-1:0]   acc_q;
    logic [WIDTH-1:0]   out_data_q;
    logic               in_ready_q;
    logic               out_valid_q;
    logic               busy_q;

    logic [WIDTH-1:0]   or_d;
    logic [WIDTH-1:0]   and_d;
    logic [WIDTH-1:0]   xor_d;
    logic [WIDTH-1:0]   red_d;
    logic [WIDTH-1:0]   acc_d;
    logic               accept_d;
    logic               last_d;

    function automatic logic c2_cell(input logic [3:0] d, input logic a1, input logic b1,
                                     input logic a0, input logic b0);
        return d[{a1 | b1, a0 & b0}];
    endfunction

    // One C2 cell per bit per operation, combining the accumulator with the incoming word.
    always_comb begin
        or_d  = '0;
        and_d = '0;
        xor_d = '0;
        for (int i = 0; i < WIDTH; i++) begin
            or_d[i]  = c2_cell(D_OR,  acc_q[i], bus.in_data[i], 1'b0, 1'b0);
            and_d[i] = c2_cell(D_AND, 1'b0, 1'b0, acc_q[i], bus.in_data[i]);
            xor_d[i] = c2_cell(D_XOR, acc_q[i], bus.in_data[i], acc_q[i], bus.in_data[i]);
        end
    end

    // Select the running operation (NOR accumulates as OR and inverts at the end);
    // the first word of a stream is a plain load.
    always_comb begin
        case (op_q)
            OP_AND:  red_d = and_d;
            OP_XOR:  red_d = xor_d;
            default: red_d = or_d;
        endcase
        acc_d    = (cnt_q == '0) ? bus.in_data : red_d;
        accept_d = (state_q == ACCUM) && bus.in_valid;
        last_d   = (cnt_q == {1'b0, len_q});
    end

    // Control FSM with registered handshake outputs and result register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            op_q        <= '0;
            len_q       <= '0;
            cnt_q       <= '0;
            acc_q       <= '0;
            out_data_q  <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        op_q       <= bus.op;
                        len_q      <= bus.len;
                        cnt_q      <= '0;
                        state_q    <= ACCUM;
                        in_ready_q <= 1'b1;
                        busy_q     <= 1'b1;
                    end
                end
                ACCUM: begin
                    if (accept_d) begin
                        acc_q <= acc_d;
                        cnt_q <= cnt_q + 1'b1;
                        if (last_d) begin
                            state_q     <= DONE;
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                            out_data_q  <= (op_q == OP_NOR) ? ~acc_d : acc_d;
                        end
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        out_data_q  <= '0;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b0;
                    out_valid_q <= 1'b0;
                    out_data_q  <= '0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_logic_stream_reducer.sv
// Scoreboard bench for logic_stream_reducer: directed streams push their
// hand-computed result; a negedge monitor compares every presented result.
module tb_logic_stream_reducer;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic_stream_reducer_if #(.WIDTH(8), .LEN_W(4)) bus ();

    logic_stream_reducer #(.WIDTH(8), .LEN_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare every cycle a result is presented; pop on hand-off.
    always @(negedge clk) begin
        if (!rst && bus.out_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL out_data unexpected result actual=%0h required=none", bus.out_data);
            end else begin
                chk("out_data", 32'(bus.out_data), 32'(exp_q[0]));
                if (bus.out_ready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic begin_op(input logic [1:0] o, input logic [3:0] l);
        bus.start = 1'b1;
        bus.op    = o;
        bus.len   = l;
        tick();
        bus.start = 1'b0;
        bus.op    = ~o;
        bus.len   = ~l;
        chk("in_ready_after_start", 32'(bus.in_ready), 1);
    endtask

    task automatic send(input logic [7:0] d, input int gap, input bit chk_gap);
        int n;
        for (int g = 0; g < gap; g++) begin
            bus.in_valid = 1'b0;
            tick();
            if (chk_gap) chk("in_ready_gap", 32'(bus.in_ready), 1);
        end
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        n = 0;
        while (!bus.in_ready && n < 20) begin
            tick();
            n++;
        end
        if (!bus.in_ready) begin
            checks++;
            errors++;
            $display("FAIL in_ready_timeout actual=0 required=1");
        end
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (bus.busy && n < 100) begin
            tick();
            n++;
        end
        chk("busy_idle_timeout", 32'(bus.busy), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start     = 1'b0;
        bus.op        = 2'b00;
        bus.len       = '0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
        #1 rst = 1'b1;
        #2;
        chk("rst_in_ready",  32'(bus.in_ready), 0);
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_out_data",  32'(bus.out_data), 0);
        chk("rst_busy",      32'(bus.busy), 0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // OR back-to-back, one-cycle result hand-off
        begin_op(2'b00, 4'd2);
        chk("or_busy", 32'(bus.busy), 1);
        exp_q.push_back(8'h91);
        send(8'h01, 0, 1'b0);
        send(8'h10, 0, 1'b0);
        send(8'h80, 0, 1'b0);
        chk("or_out_valid", 32'(bus.out_valid), 1);
        chk("or_busy_done", 32'(bus.busy), 1);
        tick();
        chk("or_out_valid_fall", 32'(bus.out_valid), 0);
        chk("or_busy_fall", 32'(bus.busy), 0);
        chk("or_out_data_idle", 32'(bus.out_data), 0);

        // AND with gaps between words
        begin_op(2'b01, 4'd2);
        exp_q.push_back(8'h0C);
        send(8'hFF, 0, 1'b1);
        send(8'h0F, 2, 1'b1);
        send(8'h3C, 2, 1'b1);
        wait_idle();

        // XOR single word (load only), then 16 words without count wrap
        begin_op(2'b10, 4'd0);
        exp_q.push_back(8'hA5);
        send(8'hA5, 0, 1'b0);
        wait_idle();
        begin_op(2'b10, 4'd15);
        exp_q.push_back(8'h10);
        for (int i = 1; i <= 16; i++) send(8'(i), 0, 1'b0);
        chk("xor_cnt16", 32'(dut.cnt_q), 16);
        chk("xor16_out_valid", 32'(bus.out_valid), 1);
        wait_idle();

        // NOR with consumer stall; command inputs toggled during DONE
        bus.out_ready = 1'b0;
        begin_op(2'b11, 4'd1);
        exp_q.push_back(8'hC0);
        send(8'h0F, 0, 1'b0);
        send(8'h30, 0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            bus.start = 1'b1;
            bus.op    = 2'($urandom);
            bus.len   = 4'($urandom);
            tick();
            chk("nor_hold_valid", 32'(bus.out_valid), 1);
        end
        chk("nor_op_kept", 32'(dut.op_q), 3);
        chk("nor_len_kept", 32'(dut.len_q), 1);
        bus.out_ready = 1'b1;
        tick();
        chk("nor_handoff_valid", 32'(bus.out_valid), 0);
        chk("nor_handoff_start_ignored", 32'(bus.busy), 0);
        bus.start = 1'b0;
        tick();
        chk("nor_stays_idle", 32'(bus.busy), 0);

        // Asynchronous abort mid-stream, then a clean OR
        begin_op(2'b01, 4'd3);
        send(8'hF0, 0, 1'b0);
        send(8'h3C, 0, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk("abort_in_ready",  32'(bus.in_ready), 0);
        chk("abort_out_valid", 32'(bus.out_valid), 0);
        chk("abort_out_data",  32'(bus.out_data), 0);
        chk("abort_busy",      32'(bus.busy), 0);
        #3 rst = 1'b0;
        tick();
        begin_op(2'b00, 4'd0);
        exp_q.push_back(8'h5A);
        send(8'h5A, 0, 1'b0);
        wait_idle();
        tick();

        chk("scoreboard_empty", 32'(exp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
